pixel_pair_processor: RTL
=========================

Name: pixel_pair_processor

Overview:
- Streaming point-operation stage that sits directly upstream of the BMP write stage.
- Accepts one RGB888 pixel pair per valid cycle, applies a frame-wide selected operation, and emits the result on a matching pair interface with a valid strobe (hsync_o) after fixed latency.
- Tracks pair position within the frame and pulses frame_done on the last output pair.

Parameters:
- WIDTH, 768, image width in pixels (even)
- HEIGHT, 512, image height in pixels
- PAIRS, WIDTH*HEIGHT/2, pixel pairs per frame (derived, not overridden)

Ports:
- HCLK  input  1  clock, rising edge
- HRESETn  input  1  asynchronous active-low reset
- hsync_i  input  1  input pair valid
- DATA_R0, DATA_G0, DATA_B0  input  8 each  first (odd) pixel of pair
- DATA_R1, DATA_G1, DATA_B1  input  8 each  second (even) pixel of pair
- mode  input  3  operation select, sampled at frame start only
- value  input  8  brightness offset, sampled with mode
- threshold  input  8  threshold level, sampled with mode
- hsync_o  output  1  output pair valid
- DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0, DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1  output  8 each  processed pair
- frame_done  output  1  one-cycle pulse with the last pair of a frame
- pair_count  output  18  index of the next pair to be accepted (0..PAIRS-1)

Behaviour:
- Reset (asynchronous, HRESETn low): all outputs 0, pipeline valid bits 0, pair_count 0, latched mode/value/threshold 0 (passthrough).
- Pipeline has 2 stages:
  - Stage 1 registers the input pair plus a valid bit and a last-pair flag.
  - Stage 2 computes the result and registers the outputs.
  - Latency: hsync_i high at edge N gives hsync_o high after edge N+2 with the corresponding data.
- The pipeline advances every cycle with no back-pressure. Bubbles (hsync_i low) propagate as hsync_o low.
- DATA_WRITE_* hold their last value while hsync_o is low.
- Parameter latch: when hsync_i=1 and pair_count=0, mode/value/threshold are captured. That setting applies to that pair and every pair of the frame. Changes on mode mid-frame are ignored.
- Operations, applied per channel unless stated:
  - 0: passthrough.
  - 1: x+value, saturated to 255 (9-bit intermediate).
  - 2: x-value, floored at 0.
  - 3: invert, 255-x.
  - 4: threshold. Per pixel s=(R+G+B)/3, 10-bit sum, exact floor divide. If s>threshold, all three channels = 255; otherwise 0. s==threshold gives 0.
  - 5: grayscale. Per pixel all channels = s.
  - 6, 7: treated as passthrough.
- pair_count increments on each hsync_i=1.
  - At PAIRS-1 it wraps to 0, and that input pair is flagged last.
  - frame_done = 1 for exactly the cycle hsync_o presents the flagged pair; otherwise 0.
- Back-to-back frames: a pair accepted at count 0 right after a wrap re-latches the parameters in the same cycle. There are no dead cycles between frames.
- Reset mid-frame: in-flight pairs are discarded (no hsync_o, no frame_done), pair_count returns to 0, and the next accepted pair starts a new frame.
- Arithmetic is unsigned throughout, and no output ever exceeds 8 bits without saturation.

Test Plan:
- Reset then passthrough: mode=0, pair (10,20,30 / 40,50,60) → two cycles later hsync_o=1 with identical outputs; all outputs 0 during reset.
- Brightness saturation: mode=1, value=100, pixel R=200,G=155,B=0 → 255,255,100. Mode=2, value=100, pixel 50,100,150 → 0,0,50.
- Threshold/grayscale: mode=4, threshold=90, pixel (90,90,93) gives s=91 → 255,255,255. Pixel (90,90,90) gives s=90 → 0,0,0. Mode=5, pixel (1,2,4) → 2,2,2.
- Mode lock: start frame with mode=3, switch mode to 0 at pair 5 → pair 5 (0,0,0) outputs 255,255,255. With WIDTH=4, HEIGHT=2 (PAIRS=4), mode=0 at pair 0 of the next frame → passthrough takes effect.
- Frame boundary: WIDTH=4, HEIGHT=2, 8 continuous valid pairs with one bubble inserted after pair 2 → frame_done pulses exactly twice, aligned with the 4th and 8th hsync_o. pair_count reads 0 after each wrap; bubble appears as hsync_o low with held data.
- Reset mid-operation: assert HRESETn low for 1 cycle with 2 pairs in flight → no hsync_o for them, pair_count=0, and the next frame completes a full PAIRS count before frame_done.

Source files
------------

// File: rtl/pixel_pair_processor.sv
// Two-stage point-operation pipeline for RGB888 pixel pairs feeding the BMP writer.
// The operation is chosen once per frame and the last pair of each frame is flagged on output.
module pixel_pair_processor #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        hsync_i,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    input  logic [2:0]  mode,
    input  logic [7:0]  value,
    input  logic [7:0]  threshold,
    output logic        hsync_o,
    output logic [7:0]  DATA_WRITE_R0,
    output logic [7:0]  DATA_WRITE_G0,
    output logic [7:0]  DATA_WRITE_B0,
    output logic [7:0]  DATA_WRITE_R1,
    output logic [7:0]  DATA_WRITE_G1,
    output logic [7:0]  DATA_WRITE_B1,
    output logic        frame_done,
    output logic [17:0] pair_count
);

    localparam int          PAIRS    = WIDTH * HEIGHT / 2;
    localparam logic [17:0] LAST_IDX = 18'(PAIRS - 1);

    localparam logic [2:0] OP_PASS   = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_INVERT = 3'd3;
    localparam logic [2:0] OP_THRESH = 3'd4;
    localparam logic [2:0] OP_GRAY   = 3'd5;

    logic [2:0]  mode_q;
    logic [7:0]  value_q;
    logic [7:0]  threshold_q;

    logic        s1_valid;
    logic        s1_last;
    logic [23:0] s1_px0;
    logic [23:0] s1_px1;

    logic [23:0] res_px0;
    logic [23:0] res_px1;

    logic        frame_start;
    logic        at_last;

    assign frame_start = hsync_i && (pair_count == 18'd0);
    assign at_last     = (pair_count == LAST_IDX);

    // Pixel packed as {R, G, B}; every channel fits in 8 bits after saturation/flooring.
    function automatic logic [23:0] apply_op(
        input logic [2:0]  op,
        input logic [7:0]  val,
        input logic [7:0]  thr,
        input logic [23:0] px
    );
        logic [23:0] res;
        logic [9:0]  sum;
        logic [7:0]  avg;
        logic [7:0]  x;
        logic [8:0]  wide;
        res  = px;
        sum  = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
        avg  = 8'(sum / 10'd3);
        for (int c = 0; c < 3; c++) begin
            x    = px[c*8 +: 8];
            wide = {1'b0, x} + {1'b0, val};
            case (op)
                OP_ADD:    res[c*8 +: 8] = wide[8] ? 8'hff : wide[7:0];
                OP_SUB:    res[c*8 +: 8] = (x > val) ? (x - val) : 8'd0;
                OP_INVERT: res[c*8 +: 8] = 8'hff - x;
                OP_THRESH: res[c*8 +: 8] = (avg > thr) ? 8'hff : 8'h00;
                OP_GRAY:   res[c*8 +: 8] = avg;
                default:   res[c*8 +: 8] = x;
            endcase
        end
        return res;
    endfunction

    // Parameters are only sampled with the first pair of a frame.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_q      <= OP_PASS;
            value_q     <= 8'd0;
            threshold_q <= 8'd0;
        end else if (frame_start) begin
            mode_q      <= mode;
            value_q     <= value;
            threshold_q <= threshold;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pair_count <= 18'd0;
        end else if (hsync_i) begin
            pair_count <= at_last ? 18'd0 : pair_count + 18'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_px0   <= 24'd0;
            s1_px1   <= 24'd0;
        end else begin
            s1_valid <= hsync_i;
            s1_last  <= hsync_i && at_last;
            if (hsync_i) begin
                s1_px0 <= {DATA_R0, DATA_G0, DATA_B0};
                s1_px1 <= {DATA_R1, DATA_G1, DATA_B1};
            end
        end
    end

    // mode_q already holds this frame's setting when its first pair sits in stage 1,
    // and still holds the old one while the previous frame's last pair is computed.
    always_comb begin
        res_px0 = apply_op(mode_q, value_q, threshold_q, s1_px0);
        res_px1 = apply_op(mode_q, value_q, threshold_q, s1_px1);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_o       <= 1'b0;
            frame_done    <= 1'b0;
            DATA_WRITE_R0 <= 8'd0;
            DATA_WRITE_G0 <= 8'd0;
            DATA_WRITE_B0 <= 8'd0;
            DATA_WRITE_R1 <= 8'd0;
            DATA_WRITE_G1 <= 8'd0;
            DATA_WRITE_B1 <= 8'd0;
        end else begin
            hsync_o    <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0} <= res_px0;
                {DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1} <= res_px1;
            end
        end
    end

endmodule
